// File: rtl/fetch_decode_queue_if.sv
// Fetch-to-decode queue interface: fetch-side push signals, decode-side
// head-of-queue signals, flush and occupancy. The queue itself is the slave.
interface fetch_decode_queue_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 32,
    parameter int DEPTH   = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    PCPlus4F;
    logic [INSTR_W-1:0] InstructionF;
    logic               predictF;
    logic               ValidF;
    logic               ReadyF;
    logic               DropF;

    logic [PC_W-1:0]    PCPlus4D;
    logic [INSTR_W-1:0] InstructionD;
    logic               predictD;
    logic               ValidD;
    logic               Decode_Enable;

    logic               Flush;
    logic [CNT_W-1:0]   Count;

    modport slave (
        input  PCPlus4F, InstructionF, predictF, ValidF, Decode_Enable, Flush,
        output ReadyF, DropF, PCPlus4D, InstructionD, predictD, ValidD, Count
    );

    modport master (
        output PCPlus4F, InstructionF, predictF, ValidF, Decode_Enable, Flush,
        input  ReadyF, DropF, PCPlus4D, InstructionD, predictD, ValidD, Count
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode decoupling FIFO. Replaces the IF/ID register with DEPTH
// entries so fetch can run ahead while decode stalls. Show-ahead output:
// the head entry is presented directly, a NOP bubble when empty.
module fetch_decode_queue #(
    parameter int          INSTR_W  = 32,
    parameter int          PC_W     = 32,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd4,
    parameter logic [31:0] FLUSH_PC = 32'd0
) (
    input  logic               Clk,
    input  logic               Reset,
    fetch_decode_queue_if.slave q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic               pred_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [PC_W-1:0]  bubble_pc;
    logic             drop_q;

    logic ready;
    logic valid;
    logic push;
    logic pop;

    // Ready depends only on occupancy, so a full queue refuses a push even
    // when decode pops in the same cycle.
    assign ready = (count != CNT_W'(DEPTH));
    assign valid = (count != '0);
    assign push  = q.ValidF & ready;
    assign pop   = valid & q.Decode_Enable;

    // Pointer, occupancy, drop pulse and bubble PC bookkeeping; Reset beats Flush beats push/pop.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop_q    <= 1'b0;
            bubble_pc <= PC_W'(RESET_PC);
        end else if (q.Flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop_q    <= 1'b0;
            bubble_pc <= PC_W'(FLUSH_PC);
        end else begin
            drop_q <= q.ValidF & ~ready;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are not architectural, so no reset is needed.
    always_ff @(posedge Clk) begin
        if (push && !Reset && !q.Flush) begin
            pc_mem[wr_ptr]    <= q.PCPlus4F;
            instr_mem[wr_ptr] <= q.InstructionF;
            pred_mem[wr_ptr]  <= q.predictF;
        end
    end

    assign q.ReadyF       = ready;
    assign q.ValidD       = valid;
    assign q.DropF        = drop_q;
    assign q.Count        = count;
    assign q.PCPlus4D     = valid ? pc_mem[rd_ptr]    : bubble_pc;
    assign q.InstructionD = valid ? instr_mem[rd_ptr] : '0;
    assign q.predictD     = valid ? pred_mem[rd_ptr]  : 1'b0;
endmodule

// File: tb/tb_fetch_decode_queue.sv
// Testbench for fetch_decode_queue: a DEPTH=4 instance driven by a vector
// table plus wrap/flush/reset sequences against a queue scoreboard, and a
// DEPTH=8, 16-bit instruction instance checked for full occupancy and order.
module tb_fetch_decode_queue;
    localparam int DEPTH    = 4;
    localparam int RESET_PC = 4;
    localparam int FLUSH_PC = 0;

    logic Clk = 1'b0;
    logic Reset;
    logic Reset8;

    // Free-running clock shared by both instances.
    always #5 Clk = ~Clk;

    fetch_decode_queue_if #(.INSTR_W(32), .PC_W(32), .DEPTH(4)) q();
    fetch_decode_queue_if #(.INSTR_W(16), .PC_W(32), .DEPTH(8)) q8();

    fetch_decode_queue #(
        .INSTR_W(32), .PC_W(32), .DEPTH(4),
        .RESET_PC(32'd4), .FLUSH_PC(32'd0)
    ) dut (
        .Clk(Clk), .Reset(Reset), .q(q)
    );

    fetch_decode_queue #(
        .INSTR_W(16), .PC_W(32), .DEPTH(8),
        .RESET_PC(32'd4), .FLUSH_PC(32'd0)
    ) dut8 (
        .Clk(Clk), .Reset(Reset8), .q(q8)
    );

    typedef struct {
        logic        rst;
        logic        flush;
        logic        vf;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
        logic        dec;
        int          exp_count;
        logic        exp_drop;
    } vec_t;

    vec_t        vecs[$];
    logic [64:0] sb[$];
    logic [31:0] m_bubble;
    logic        m_drop;
    int          n_checks = 0;
    int          n_errors = 0;

    function automatic vec_t mk(logic rst, logic flush, logic vf, logic [31:0] instr,
                                logic [31:0] pc, logic pred, logic dec,
                                int exp_count, logic exp_drop);
        vec_t v;
        v.rst = rst; v.flush = flush; v.vf = vf; v.instr = instr; v.pc = pc;
        v.pred = pred; v.dec = dec; v.exp_count = exp_count; v.exp_drop = exp_drop;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs, advances the scoreboard with the pre-edge state, then waits to the sampling edge.
    task automatic applyStimulus(input logic rst, input logic flush, input logic vf,
                                 input logic [31:0] instr, input logic [31:0] pc,
                                 input logic pred, input logic dec);
        bit m_ready;
        bit m_valid;
        Reset           = rst;
        q.Flush         = flush;
        q.ValidF        = vf;
        q.InstructionF  = instr;
        q.PCPlus4F      = pc;
        q.predictF      = pred;
        q.Decode_Enable = dec;
        if (rst) begin
            sb.delete();
            m_bubble = 32'(RESET_PC);
            m_drop   = 1'b0;
        end else if (flush) begin
            sb.delete();
            m_bubble = 32'(FLUSH_PC);
            m_drop   = 1'b0;
        end else begin
            m_ready = (sb.size() != DEPTH);
            m_valid = (sb.size() != 0);
            m_drop  = vf & ~m_ready;
            if (m_valid && dec) void'(sb.pop_front());
            if (vf && m_ready) sb.push_back({pred, pc, instr});
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    // Compares every DUT output against the scoreboard head or the expected bubble.
    task automatic checkOutput(input string tag);
        if (sb.size() != 0) begin
            check({tag, ".ValidD"}, 64'(q.ValidD), 64'd1);
            check({tag, ".InstructionD"}, 64'(q.InstructionD), 64'(sb[0][31:0]));
            check({tag, ".PCPlus4D"}, 64'(q.PCPlus4D), 64'(sb[0][63:32]));
            check({tag, ".predictD"}, 64'(q.predictD), 64'(sb[0][64]));
        end else begin
            check({tag, ".ValidD"}, 64'(q.ValidD), 64'd0);
            check({tag, ".InstructionD"}, 64'(q.InstructionD), 64'd0);
            check({tag, ".PCPlus4D"}, 64'(q.PCPlus4D), 64'(m_bubble));
            check({tag, ".predictD"}, 64'(q.predictD), 64'd0);
        end
        check({tag, ".Count"}, 64'(q.Count), 64'(sb.size()));
        check({tag, ".ReadyF"}, 64'(q.ReadyF), 64'(sb.size() != DEPTH));
        check({tag, ".DropF"}, 64'(q.DropF), 64'(m_drop));
    endtask

    // Main test sequence.
    initial begin
        m_bubble = 32'(RESET_PC);
        m_drop   = 1'b0;
        Reset8   = 1'b1;
        q8.ValidF = 1'b0; q8.Flush = 1'b0; q8.Decode_Enable = 1'b0;
        q8.InstructionF = '0; q8.PCPlus4F = '0; q8.predictF = 1'b0;

        // Reset, idle, single pass-through entry, fill to full with drop, refused push while popping, drain.
        vecs.push_back(mk(1, 0, 0, 32'h0,        32'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'h20000001, 32'd8,  1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'hA0000001, 32'h10, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'hA0000002, 32'h14, 0, 0, 2, 0));
        vecs.push_back(mk(0, 0, 1, 32'hA0000003, 32'h18, 1, 0, 3, 0));
        vecs.push_back(mk(0, 0, 1, 32'hA0000004, 32'h1C, 0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 1, 32'hA0000005, 32'h20, 1, 0, 4, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,  0, 0, 4, 0));
        vecs.push_back(mk(0, 0, 1, 32'hA0000006, 32'h24, 1, 1, 3, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,  0, 1, 2, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,  0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        32'h0,  0, 1, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].rst, vecs[i].flush, vecs[i].vf, vecs[i].instr,
                          vecs[i].pc, vecs[i].pred, vecs[i].dec);
            checkOutput($sformatf("vec%0d", i));
            check($sformatf("vec%0d.tableCount", i), 64'(q.Count), 64'(vecs[i].exp_count));
            check($sformatf("vec%0d.tableDrop", i), 64'(q.DropF), 64'(vecs[i].exp_drop));
        end

        // Steady-state push+pop at three entries forces both pointers through their wrap.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 32'hB0000000 + 32'(i), 32'h200 + 32'(4 * i), i[0], 0);
            checkOutput($sformatf("wfill%0d", i));
        end
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 1, 32'hC0000000 + 32'(i), 32'h300 + 32'(4 * i), ~i[0], 1);
            checkOutput($sformatf("wrap%0d", i));
            check($sformatf("wrap%0d.Count3", i), 64'(q.Count), 64'd3);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 1);
            checkOutput($sformatf("wdrain%0d", i));
        end

        // Flush with three queued entries and a concurrent push.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 1, 32'hD0000000 + 32'(i), 32'h400 + 32'(4 * i), 1, 0);
        end
        applyStimulus(0, 1, 1, 32'hDEADBEEF, 32'h500, 1, 1);
        checkOutput("flush");
        check("flush.Count0", 64'(q.Count), 64'd0);
        check("flush.ValidD0", 64'(q.ValidD), 64'd0);
        check("flush.PCPlus4D", 64'(q.PCPlus4D), 64'd0);
        check("flush.InstructionD", 64'(q.InstructionD), 64'd0);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 0, 0);
        check("flush.pushDiscarded", 64'(q.Count), 64'd0);

        // Flush while full with ValidF high must not raise DropF.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 32'hE0000000 + 32'(i), 32'h600 + 32'(4 * i), 0, 0);
        end
        applyStimulus(0, 1, 1, 32'hE0000009, 32'h700, 0, 0);
        checkOutput("flushFull");
        check("flushFull.DropF", 64'(q.DropF), 64'd0);

        // Reset together with Flush while full: the reset bubble wins.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 1, 32'hF0000000 + 32'(i), 32'h800 + 32'(4 * i), 1, 0);
        end
        check("full.ReadyF", 64'(q.ReadyF), 64'd0);
        applyStimulus(1, 1, 1, 32'h12345678, 32'h900, 1, 1);
        checkOutput("rstFlush");
        check("rstFlush.PCPlus4D", 64'(q.PCPlus4D), 64'd4);
        check("rstFlush.Count", 64'(q.Count), 64'd0);
        Reset = 1'b0;

        // DEPTH=8 instance: occupancy must reach 8, ninth push drops, order preserved.
        Reset8 = 1'b1;
        @(posedge Clk); @(negedge Clk);
        Reset8 = 1'b0;
        check("d8.reset.Count", 64'(q8.Count), 64'd0);
        check("d8.reset.PCPlus4D", 64'(q8.PCPlus4D), 64'd4);
        for (int i = 0; i < 9; i++) begin
            q8.ValidF       = 1'b1;
            q8.InstructionF = 16'hA000 + 16'(i);
            q8.PCPlus4F     = 32'h100 + 32'(4 * i);
            q8.predictF     = i[0];
            @(posedge Clk); @(negedge Clk);
            check($sformatf("d8.push%0d.Count", i), 64'(q8.Count), 64'((i < 8) ? i + 1 : 8));
            check($sformatf("d8.push%0d.DropF", i), 64'(q8.DropF), 64'(i == 8));
        end
        check("d8.full.ReadyF", 64'(q8.ReadyF), 64'd0);
        q8.ValidF = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("d8.pop%0d.InstructionD", i), 64'(q8.InstructionD), 64'(16'hA000 + 16'(i)));
            check($sformatf("d8.pop%0d.PCPlus4D", i), 64'(q8.PCPlus4D), 64'(32'h100 + 32'(4 * i)));
            check($sformatf("d8.pop%0d.predictD", i), 64'(q8.predictD), 64'(i % 2));
            q8.Decode_Enable = 1'b1;
            @(posedge Clk); @(negedge Clk);
        end
        q8.Decode_Enable = 1'b0;
        check("d8.empty.ValidD", 64'(q8.ValidD), 64'd0);
        check("d8.empty.Count", 64'(q8.Count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
